// File: rtl/ddr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ddr_ctrl_pkg
// Description : Constants shared by the DDR2 ring address generator:
//               default address width, words per burst and the encoding
//               of the read-gating FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package ddr_ctrl_pkg;

    // Width of the controller local_address bus (32-bit word addressing)
    localparam int ADDR_WIDTH = 25;

    // Words moved per burst; also the pointer step
    localparam int BURST_LEN  = 4;

    // Read gating FSM: PRIME waits for the ring to fill, STREAM allows reads
    typedef enum logic {
        PRIME  = 1'b0,
        STREAM = 1'b1
    } rd_state_e;

endpackage : ddr_ctrl_pkg
`default_nettype wire

// File: rtl/ddr_ring_ptr.sv
`default_nettype none
// ============================================================================
// Module      : ddr_ring_ptr
// Description : Burst pointer for a circular region of DDR2. Steps by
//               BURST_LEN and wraps from the last slot back to RING_BASE.
//               Reset and load both return the pointer to RING_BASE.
// Ports       : clk_i   - clock
//               rst_i   - synchronous active-high reset (highest priority)
//               load_i  - synchronous return to RING_BASE
//               step_i  - advance by one burst slot
//               ptr_o   - current burst start address (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_ring_ptr #(
    parameter int          ADDR_WIDTH = 25,
    parameter int          BURST_LEN  = 4,
    parameter int unsigned RING_BASE  = 32'h0,
    parameter int unsigned RING_SIZE  = 32'h100000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic                  step_i,
    output logic [ADDR_WIDTH-1:0] ptr_o
);

    localparam logic [ADDR_WIDTH-1:0] C_BASE = ADDR_WIDTH'(RING_BASE);
    // One past the last word of the ring; one extra bit so the compare
    // cannot alias when the ring ends at the top of the address space.
    localparam logic [ADDR_WIDTH:0]   C_END  = (ADDR_WIDTH+1)'(RING_BASE + RING_SIZE);
    localparam logic [ADDR_WIDTH:0]   C_STEP = (ADDR_WIDTH+1)'(BURST_LEN);

    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] ptr_d;
    logic [ADDR_WIDTH:0]   sum_w;

    always_comb begin
        sum_w = {1'b0, ptr_q} + C_STEP;
        ptr_d = ptr_q;
        if (step_i) begin
            ptr_d = (sum_w == C_END) ? C_BASE : sum_w[ADDR_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || load_i) begin
            ptr_q <= C_BASE;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule : ddr_ring_ptr
`default_nettype wire

// File: rtl/ddr_ring_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : ddr_ring_addr_gen
// Description : Write/read address generator that treats DDR2 as a circular
//               buffer of BURST_LEN-word slots between the AD capture FIFO
//               and the wavelet FIFO. Tracks fill level, full/empty flags,
//               sticky overflow/underflow and gates reads until READ_THRESH
//               slots are filled.
// Ports       : phy_clk     - controller half-rate clock
//               rst         - synchronous active-high reset
//               clear       - synchronous flush, keeps sticky error flags
//               wr_addr_up  - one write burst accepted at wr_addr
//               rd_addr_up  - one read burst accepted at rd_addr
//               wr_addr     - next write burst start address
//               rd_addr     - next read burst start address
//               read_en     - read may be granted
//               ring_full   - all slots filled
//               ring_empty  - no slot filled
//               fill_level  - number of filled slots
//               overflow    - sticky: write refused while full
//               underflow   - sticky: read pulse while empty
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_ring_addr_gen #(
    parameter int          ADDR_WIDTH  = ddr_ctrl_pkg::ADDR_WIDTH,
    parameter int          BURST_LEN   = ddr_ctrl_pkg::BURST_LEN,
    parameter int unsigned RING_BASE   = 32'h0,
    parameter int unsigned RING_SIZE   = 32'h100000,
    parameter int          READ_THRESH = 2,
    parameter bit          OVERWRITE   = 1'b0,
    localparam int         SLOTS       = RING_SIZE / BURST_LEN,
    localparam int         FW          = $clog2(SLOTS + 1)
) (
    input  logic                  phy_clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  wr_addr_up,
    input  logic                  rd_addr_up,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  read_en,
    output logic                  ring_full,
    output logic                  ring_empty,
    output logic [FW-1:0]         fill_level,
    output logic                  overflow,
    output logic                  underflow
);

    import ddr_ctrl_pkg::*;

    localparam logic [FW-1:0] C_SLOTS  = FW'(SLOTS);
    localparam logic [FW-1:0] C_THRESH = FW'(READ_THRESH);

    logic [FW-1:0] fill_q, fill_d;
    logic          full_q, empty_q;
    logic          ovf_q, udf_q;
    rd_state_e     state_q, state_d;

    logic wr_adv_w, rd_adv_w, inc_w, dec_w, ovf_set_w, udf_set_w;

    // ------------------------------------------------------------------
    // Pulse decode. Decisions use the registered flags, which always
    // match the current fill count.
    // ------------------------------------------------------------------
    always_comb begin
        wr_adv_w  = 1'b0;
        rd_adv_w  = 1'b0;
        inc_w     = 1'b0;
        dec_w     = 1'b0;
        ovf_set_w = 1'b0;
        udf_set_w = 1'b0;
        case ({wr_addr_up, rd_addr_up})
            2'b10: begin
                if (!full_q) begin
                    wr_adv_w = 1'b1;
                    inc_w    = 1'b1;
                end else if (OVERWRITE) begin
                    // Oldest slot is dropped: reader is pushed ahead of writer
                    wr_adv_w = 1'b1;
                    rd_adv_w = 1'b1;
                end else begin
                    ovf_set_w = 1'b1;
                end
            end
            2'b01: begin
                if (!empty_q) begin
                    rd_adv_w = 1'b1;
                    dec_w    = 1'b1;
                end else begin
                    udf_set_w = 1'b1;
                end
            end
            2'b11: begin
                if (!empty_q) begin
                    // Net fill unchanged, so this is safe even when full
                    wr_adv_w = 1'b1;
                    rd_adv_w = 1'b1;
                end else begin
                    // Nothing to read yet: the write lands, the read is an error
                    wr_adv_w  = 1'b1;
                    inc_w     = 1'b1;
                    udf_set_w = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        fill_d = fill_q;
        if (inc_w) begin
            fill_d = fill_q + FW'(1);
        end else if (dec_w) begin
            fill_d = fill_q - FW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Read gating FSM, evaluated on the fill value being loaded this cycle
    // so read_en lines up with fill_level.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            PRIME:   if (fill_d >= C_THRESH) state_d = STREAM;
            STREAM:  if (fill_d == '0)       state_d = PRIME;
            default: state_d = PRIME;
        endcase
    end

    always_ff @(posedge phy_clk) begin
        if (rst || clear) begin
            state_q <= PRIME;
            fill_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            full_q  <= (fill_d == C_SLOTS);
            empty_q <= (fill_d == '0);
        end
    end

    // Sticky errors survive clear; only rst drops them
    always_ff @(posedge phy_clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (!clear) begin
            if (ovf_set_w) ovf_q <= 1'b1;
            if (udf_set_w) udf_q <= 1'b1;
        end
    end

    ddr_ring_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BURST_LEN  (BURST_LEN),
        .RING_BASE  (RING_BASE),
        .RING_SIZE  (RING_SIZE)
    ) u_wr_ptr (
        .clk_i  (phy_clk),
        .rst_i  (rst),
        .load_i (clear),
        .step_i (wr_adv_w),
        .ptr_o  (wr_addr)
    );

    ddr_ring_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BURST_LEN  (BURST_LEN),
        .RING_BASE  (RING_BASE),
        .RING_SIZE  (RING_SIZE)
    ) u_rd_ptr (
        .clk_i  (phy_clk),
        .rst_i  (rst),
        .load_i (clear),
        .step_i (rd_adv_w),
        .ptr_o  (rd_addr)
    );

    assign read_en    = (state_q == STREAM);
    assign ring_full  = full_q;
    assign ring_empty = empty_q;
    assign fill_level = fill_q;
    assign overflow   = ovf_q;
    assign underflow  = udf_q;

endmodule : ddr_ring_addr_gen
`default_nettype wire

// File: tb/tb_ddr_ring_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_ring_addr_gen
// Description : Directed bench for ddr_ring_addr_gen with a 4-slot ring at
//               0x100. One instance refuses writes when full, a second one
//               overwrites the oldest slot; both see the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_ring_addr_gen;

    localparam int AW = 25;
    localparam int FW = 3;

    logic phy_clk = 1'b0;
    always #5 phy_clk = ~phy_clk;

    logic rst, clear, wr_addr_up, rd_addr_up;

    logic [AW-1:0] wr0, rd0, wr1, rd1;
    logic [FW-1:0] fill0, fill1;
    logic ren0, full0, empty0, ovf0, udf0;
    logic ren1, full1, empty1, ovf1, udf1;

    ddr_ring_addr_gen #(
        .ADDR_WIDTH(AW), .BURST_LEN(4), .RING_BASE(32'h100), .RING_SIZE(16),
        .READ_THRESH(2), .OVERWRITE(1'b0)
    ) u_dut0 (
        .phy_clk(phy_clk), .rst(rst), .clear(clear),
        .wr_addr_up(wr_addr_up), .rd_addr_up(rd_addr_up),
        .wr_addr(wr0), .rd_addr(rd0), .read_en(ren0),
        .ring_full(full0), .ring_empty(empty0), .fill_level(fill0),
        .overflow(ovf0), .underflow(udf0)
    );

    ddr_ring_addr_gen #(
        .ADDR_WIDTH(AW), .BURST_LEN(4), .RING_BASE(32'h100), .RING_SIZE(16),
        .READ_THRESH(2), .OVERWRITE(1'b1)
    ) u_dut1 (
        .phy_clk(phy_clk), .rst(rst), .clear(clear),
        .wr_addr_up(wr_addr_up), .rd_addr_up(rd_addr_up),
        .wr_addr(wr1), .rd_addr(rd1), .read_en(ren1),
        .ring_full(full1), .ring_empty(empty1), .fill_level(fill1),
        .overflow(ovf1), .underflow(udf1)
    );

    // Output snapshot: {wr, rd, fill, full, empty, read_en, overflow, underflow}
    typedef logic [AW+AW+FW+5-1:0] snap_t;

    typedef struct {
        logic rs, cl, w, r;
        snap_t exp;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic snap_t mk(input logic [AW-1:0] wr, input logic [AW-1:0] rd,
                                 input logic [FW-1:0] fill, input logic full,
                                 input logic empty, input logic ren,
                                 input logic ovf, input logic udf);
        return {wr, rd, fill, full, empty, ren, ovf, udf};
    endfunction

    function automatic vec_t v(input logic rs, input logic cl, input logic w,
                               input logic r, input snap_t exp);
        vec_t t;
        t.rs = rs; t.cl = cl; t.w = w; t.r = r; t.exp = exp;
        return t;
    endfunction

    task automatic check(input string name, input snap_t act, input snap_t exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got wr=%h rd=%h fill=%0d full=%b empty=%b ren=%b ovf=%b udf=%b, expected wr=%h rd=%h fill=%0d full=%b empty=%b ren=%b ovf=%b udf=%b",
                     name,
                     act[57:33], act[32:8], act[7:5], act[4], act[3], act[2], act[1], act[0],
                     exp[57:33], exp[32:8], exp[7:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge
    task automatic cyc(input logic rs, input logic cl, input logic w, input logic r);
        rst = rs; clear = cl; wr_addr_up = w; rd_addr_up = r;
        @(posedge phy_clk);
        #1;
        rst = 1'b0; clear = 1'b0; wr_addr_up = 1'b0; rd_addr_up = 1'b0;
    endtask

    vec_t tbl[$];

    initial begin
        snap_t RST;
        RST = mk(25'h100, 25'h100, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        rst = 1'b1; clear = 1'b0; wr_addr_up = 1'b0; rd_addr_up = 1'b0;

        // Fill to 3, drain with three reads (no underflow)
        tbl.push_back(v(1,0,0,0, RST));
        tbl.push_back(v(0,0,1,0, mk(25'h104, 25'h100, 1, 0, 0, 0, 0, 0)));
        tbl.push_back(v(0,0,1,0, mk(25'h108, 25'h100, 2, 0, 0, 1, 0, 0)));
        tbl.push_back(v(0,0,1,0, mk(25'h10C, 25'h100, 3, 0, 0, 1, 0, 0)));
        tbl.push_back(v(0,0,0,1, mk(25'h10C, 25'h104, 2, 0, 0, 1, 0, 0)));
        tbl.push_back(v(0,0,0,1, mk(25'h10C, 25'h108, 1, 0, 0, 1, 0, 0)));
        tbl.push_back(v(0,0,0,1, mk(25'h10C, 25'h10C, 0, 0, 1, 0, 0, 0)));
        tbl.push_back(v(0,0,0,0, mk(25'h10C, 25'h10C, 0, 0, 1, 0, 0, 0)));
        // Wrap to full, then refused write
        tbl.push_back(v(1,0,0,0, RST));
        tbl.push_back(v(0,0,1,0, mk(25'h104, 25'h100, 1, 0, 0, 0, 0, 0)));
        tbl.push_back(v(0,0,1,0, mk(25'h108, 25'h100, 2, 0, 0, 1, 0, 0)));
        tbl.push_back(v(0,0,1,0, mk(25'h10C, 25'h100, 3, 0, 0, 1, 0, 0)));
        tbl.push_back(v(0,0,1,0, mk(25'h100, 25'h100, 4, 1, 0, 1, 0, 0)));
        tbl.push_back(v(0,0,1,0, mk(25'h100, 25'h100, 4, 1, 0, 1, 1, 0)));
        // Full, then simultaneous write+read
        tbl.push_back(v(1,0,0,0, RST));
        tbl.push_back(v(0,0,1,0, mk(25'h104, 25'h100, 1, 0, 0, 0, 0, 0)));
        tbl.push_back(v(0,0,1,0, mk(25'h108, 25'h100, 2, 0, 0, 1, 0, 0)));
        tbl.push_back(v(0,0,1,0, mk(25'h10C, 25'h100, 3, 0, 0, 1, 0, 0)));
        tbl.push_back(v(0,0,1,0, mk(25'h100, 25'h100, 4, 1, 0, 1, 0, 0)));
        tbl.push_back(v(0,0,1,1, mk(25'h104, 25'h104, 4, 1, 0, 1, 0, 0)));
        // Empty, then simultaneous write+read
        tbl.push_back(v(1,0,0,0, RST));
        tbl.push_back(v(0,0,1,1, mk(25'h104, 25'h100, 1, 0, 0, 0, 0, 1)));
        // Read when empty; underflow survives clear, drops on rst
        tbl.push_back(v(1,0,0,0, RST));
        tbl.push_back(v(0,0,0,1, mk(25'h100, 25'h100, 0, 0, 1, 0, 0, 1)));
        tbl.push_back(v(0,1,0,0, mk(25'h100, 25'h100, 0, 0, 1, 0, 0, 1)));
        tbl.push_back(v(1,0,0,0, RST));
        // clear at fill=3 together with a write pulse
        tbl.push_back(v(0,0,1,0, mk(25'h104, 25'h100, 1, 0, 0, 0, 0, 0)));
        tbl.push_back(v(0,0,1,0, mk(25'h108, 25'h100, 2, 0, 0, 1, 0, 0)));
        tbl.push_back(v(0,0,1,0, mk(25'h10C, 25'h100, 3, 0, 0, 1, 0, 0)));
        tbl.push_back(v(0,1,1,0, RST));
        // rst wins over clear and pulses
        tbl.push_back(v(0,0,1,0, mk(25'h104, 25'h100, 1, 0, 0, 0, 0, 0)));
        tbl.push_back(v(1,1,1,1, RST));

        repeat (2) @(posedge phy_clk);
        #1;

        foreach (tbl[i]) begin
            cyc(tbl[i].rs, tbl[i].cl, tbl[i].w, tbl[i].r);
            check($sformatf("row%0d", i),
                  {wr0, rd0, fill0, full0, empty0, ren0, ovf0, udf0}, tbl[i].exp);
        end

        // Overwrite variant: write when full drops the oldest slot
        cyc(1,0,0,0);
        repeat (4) cyc(0,0,1,0);
        check("ovw_full", {wr1, rd1, fill1, full1, empty1, ren1, ovf1, udf1},
              mk(25'h100, 25'h100, 4, 1, 0, 1, 0, 0));
        cyc(0,0,1,0);
        check("ovw_drop1", {wr1, rd1, fill1, full1, empty1, ren1, ovf1, udf1},
              mk(25'h104, 25'h104, 4, 1, 0, 1, 0, 0));
        check("ovw_refuse", {wr0, rd0, fill0, full0, empty0, ren0, ovf0, udf0},
              mk(25'h100, 25'h100, 4, 1, 0, 1, 1, 0));
        cyc(0,0,1,0);
        check("ovw_drop2", {wr1, rd1, fill1, full1, empty1, ren1, ovf1, udf1},
              mk(25'h108, 25'h108, 4, 1, 0, 1, 0, 0));
        cyc(0,0,1,1);
        check("ovw_wr_rd_full", {wr1, rd1, fill1, full1, empty1, ren1, ovf1, udf1},
              mk(25'h10C, 25'h10C, 4, 1, 0, 1, 0, 0));
        repeat (3) cyc(0,0,0,1);
        check("ovw_drain3", {wr1, rd1, fill1, full1, empty1, ren1, ovf1, udf1},
              mk(25'h10C, 25'h108, 1, 0, 0, 1, 0, 0));
        cyc(0,0,0,1);
        check("ovw_drain4", {wr1, rd1, fill1, full1, empty1, ren1, ovf1, udf1},
              mk(25'h10C, 25'h10C, 0, 0, 1, 0, 0, 0));
        cyc(0,0,0,1);
        check("ovw_udf", {wr1, rd1, fill1, full1, empty1, ren1, ovf1, udf1},
              mk(25'h10C, 25'h10C, 0, 0, 1, 0, 0, 1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_ddr_ring_addr_gen
`default_nettype wire
